// File: rtl/mips_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, execute redirect,
// and the decode-side valid/ready handshake with queue status.
interface mips_fetch_unit_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            imem_en;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            dec_valid;
   logic            dec_ready;
   logic [31:0]     dec_instr;
   logic [XLEN-1:0] dec_pc;
   logic [XLEN-1:0] dec_pc4;
   logic [CW-1:0]   q_count;
   logic            fetch_fault;

   // Fetch unit side
   modport master (
      output imem_en, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc4,
             q_count, fetch_fault,
      input  imem_rdata, redirect_valid, redirect_pc, dec_ready
   );

   // Memory / execute / decode side
   modport slave (
      input  imem_en, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc4,
             q_count, fetch_fault,
      output imem_rdata, redirect_valid, redirect_pc, dec_ready
   );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: owns the PC, issues pipelined reads to a
// 1-cycle synchronous instruction memory, buffers words in a DEPTH-entry
// prefetch queue and presents {instr, pc, pc+4} to decode. J/JAL targets are
// resolved locally; branch/JR redirects come from execute.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a
// sticky fetch_fault and parks the unit in HALT until reset. Without it the
// low redirect bits are ignored and fetch_fault is tied low.
module mips_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst_n,
   mips_fetch_unit_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = CW + 1;
   localparam logic [5:0]  OP_J   = 6'h02;
   localparam logic [5:0]  OP_JAL = 6'h03;

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
`else
   typedef enum logic {RUN = 1'b0} state_t;
`endif

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q;
   logic            inflight_q;
   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [OW-1:0]   occ;
   logic [XLEN-1:0] resp_pc4, jtarget, redir_pc;
   logic            is_jump, issue, push, pop, flush, jpred;

   // Response-side decode: link address, J/JAL detection and target
   assign resp_pc4 = req_pc_q + XLEN'(4);
   assign is_jump  = (bus.imem_rdata[31:26] == OP_J) || (bus.imem_rdata[31:26] == OP_JAL);
   assign jtarget  = (resp_pc4 & ~XLEN'(32'h0FFF_FFFF)) | XLEN'({bus.imem_rdata[25:0], 2'b00});
   assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
   // Outstanding work counts against queue space so a push can never overflow
   assign occ      = OW'(count_q) + OW'(inflight_q);
   assign pop      = bus.dec_valid && bus.dec_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next state, issue/push decisions and next PC; redirect outranks everything
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      issue   = 1'b0;
      push    = 1'b0;
      jpred   = 1'b0;
      flush   = 1'b0;
      if (state_q == RUN) begin
         if (bus.redirect_valid) begin
            flush = 1'b1;
            pc_d  = redir_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) state_d = HALT;
`endif
         end else begin
            push  = inflight_q;
            jpred = inflight_q && is_jump;
            if (jpred) begin
               pc_d = jtarget;
            end else if (rst_n && (occ < OW'(DEPTH))) begin
               issue = 1'b1;
               pc_d  = pc_q + XLEN'(4);
            end
         end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else begin
         flush = 1'b1;
      end
`endif
   end

   // PC, in-flight tracking and queue pointers/occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= issue;
         if (issue) req_pc_q <= pc_q;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
         end
      end
   end

   // Queue storage; entries are only meaningful once pushed
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= bus.imem_rdata;
         pc_mem[wr_ptr_q]    <= req_pc_q;
      end
   end

   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc_q;
   assign bus.dec_valid = (count_q != '0);
   assign bus.dec_instr = instr_mem[rd_ptr_q];
   assign bus.dec_pc    = pc_mem[rd_ptr_q];
   assign bus.dec_pc4   = pc_mem[rd_ptr_q] + XLEN'(4);
   assign bus.q_count   = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
   assign bus.fetch_fault = (state_q == HALT);
`else
   assign bus.fetch_fault = 1'b0;
`endif
endmodule
